// File: rtl/leve1_pkg.sv
// Shared types and helpers for the decode stage.
//   XLEN       : datapath width (64)
//   opclass_t  : instruction class produced by decode
//   dec_t      : one decoded fetch beat as held in the decode registers
//   classify() : opcode/funct legality check -> class (OcIllegal when rejected)
//   writes_rd(), uses_rs1(), uses_rs2() : per-class register usage
package leve1_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [3:0] {
        OcLoad    = 4'd0,
        OcStore   = 4'd1,
        OcBranch  = 4'd2,
        OcJal     = 4'd3,
        OcJalr    = 4'd4,
        OcLui     = 4'd5,
        OcAuipc   = 4'd6,
        OcOpImm   = 4'd7,
        OcOp      = 4'd8,
        OcOpImm32 = 4'd9,
        OcOp32    = 4'd10,
        OcMiscMem = 4'd11,
        OcSystem  = 4'd12,
        OcIllegal = 4'd13
    } opclass_t;

    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcOp32    = 7'b0111011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        opclass_t        opclass;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            rd_we;
        logic            rs1_en;
        logic            rs2_en;
        logic            illegal;
    } dec_t;

    // Every listed opcode ends in 2'b11, so a compressed/garbage low pair
    // falls through to the default arm and is rejected there.
    function automatic opclass_t classify(input logic [31:0] instr);
        logic [2:0] f3;
        logic [6:0] f7;
        opclass_t   oc;
        f3 = instr[14:12];
        f7 = instr[31:25];
        oc = OcIllegal;
        case (instr[6:0])
            OpcLoad:    oc = (f3 == 3'b111) ? OcIllegal : OcLoad;
            OpcStore:   oc = f3[2] ? OcIllegal : OcStore;
            OpcBranch:  oc = (f3[2:1] == 2'b01) ? OcIllegal : OcBranch;
            OpcJal:     oc = OcJal;
            OpcJalr:    oc = (f3 == 3'b000) ? OcJalr : OcIllegal;
            OpcLui:     oc = OcLui;
            OpcAuipc:   oc = OcAuipc;
            OpcOpImm: begin
                // funct3 001/101 are the shifts; bit 25 is shamt[5] on RV64
                if (f3[1:0] == 2'b01 &&
                    !(instr[31:26] == 6'b000000 || instr[31:26] == 6'b010000)) begin
                    oc = OcIllegal;
                end else begin
                    oc = OcOpImm;
                end
            end
            OpcOp, OpcOp32: begin
                if (f7 == 7'b0000000 ||
                    (f7 == Funct7Alt && (f3 == 3'b000 || f3 == 3'b101))) begin
                    oc = (instr[3]) ? OcOp32 : OcOp;
                end else begin
                    oc = OcIllegal;
                end
            end
            OpcOpImm32: begin
                if (f3 == 3'b000) begin
                    oc = OcOpImm32;
                end else if ((f3 == 3'b001 || f3 == 3'b101) &&
                             (f7 == 7'b0000000 || f7 == Funct7Alt)) begin
                    oc = OcOpImm32;
                end else begin
                    oc = OcIllegal;
                end
            end
            OpcMiscMem: oc = OcMiscMem;
            OpcSystem:  oc = OcSystem;
            default:    oc = OcIllegal;
        endcase
        return oc;
    endfunction

    // SYSTEM is treated as not writing rd; CSR side effects are handled later.
    function automatic logic writes_rd(input opclass_t oc);
        case (oc)
            OcLoad, OcJal, OcJalr, OcLui, OcAuipc,
            OcOpImm, OcOp, OcOpImm32, OcOp32: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input opclass_t oc);
        case (oc)
            OcLoad, OcStore, OcBranch, OcJalr,
            OcOpImm, OcOp, OcOpImm32, OcOp32: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input opclass_t oc);
        case (oc)
            OcStore, OcBranch, OcOp, OcOp32: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/leve1_imm_gen.sv
// Combinational immediate generator.
//   instr_i   : raw 32-bit instruction
//   opclass_i : class from leve1_pkg::classify
//   imm_o     : immediate sign-extended from instr[31] to XLEN; 0 for R-type/illegal
module leve1_imm_gen
    import leve1_pkg::*;
(
    input  logic [31:0]     instr_i,
    input  opclass_t        opclass_i,
    output logic [XLEN-1:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (opclass_i)
            OcLoad, OcJalr, OcOpImm, OcOpImm32, OcMiscMem, OcSystem: begin
                imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
            end
            OcStore: begin
                imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OcBranch: begin
                imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            end
            OcLui, OcAuipc: begin
                imm_o = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
            end
            OcJal: begin
                imm_o = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            end
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/leve1_decode.sv
// Decode stage: decodes each fetch beat combinationally and stores the result
// in a main register backed by one skid register, so IF_READY is a pure flop.
//   CLK, RST (sync, active-high), FLUSH (redirect, drops everything held/incoming)
//   IF_VALID/IF_READY, IF_PC, IF_INSTR : upstream fetch handshake
//   ID_VALID/ID_READY                   : downstream handshake
//   ID_PC, ID_INSTR, ID_OPCLASS, ID_RD, ID_RS1, ID_RS2, ID_FUNCT3, ID_FUNCT7,
//   ID_IMM, ID_RD_WE, ID_RS1_EN, ID_RS2_EN, ID_ILLEGAL : registered decode result
module leve1_decode
    import leve1_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            FLUSH,
    input  logic            IF_VALID,
    input  logic [XLEN-1:0] IF_PC,
    input  logic [31:0]     IF_INSTR,
    output logic            IF_READY,
    output logic            ID_VALID,
    input  logic            ID_READY,
    output logic [XLEN-1:0] ID_PC,
    output logic [31:0]     ID_INSTR,
    output opclass_t        ID_OPCLASS,
    output logic [4:0]      ID_RD,
    output logic [4:0]      ID_RS1,
    output logic [4:0]      ID_RS2,
    output logic [2:0]      ID_FUNCT3,
    output logic [6:0]      ID_FUNCT7,
    output logic [XLEN-1:0] ID_IMM,
    output logic            ID_RD_WE,
    output logic            ID_RS1_EN,
    output logic            ID_RS2_EN,
    output logic            ID_ILLEGAL
);

    opclass_t        in_class;
    logic [XLEN-1:0] in_imm;
    dec_t            in_dec;

    dec_t main_q, main_d;
    dec_t skid_q, skid_d;
    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic if_ready_q;

    logic fire_in;
    logic main_free;

    always_comb in_class = classify(IF_INSTR);

    leve1_imm_gen u_imm_gen (
        .instr_i   (IF_INSTR),
        .opclass_i (in_class),
        .imm_o     (in_imm)
    );

    // Illegal is its own class, so the per-class usage helpers already zero
    // the enables for it.
    always_comb begin
        in_dec         = '0;
        in_dec.pc      = IF_PC;
        in_dec.instr   = IF_INSTR;
        in_dec.opclass = in_class;
        in_dec.rd      = IF_INSTR[11:7];
        in_dec.rs1     = IF_INSTR[19:15];
        in_dec.rs2     = IF_INSTR[24:20];
        in_dec.funct3  = IF_INSTR[14:12];
        in_dec.funct7  = IF_INSTR[31:25];
        in_dec.imm     = in_imm;
        in_dec.rd_we   = writes_rd(in_class) && (IF_INSTR[11:7] != 5'd0);
        in_dec.rs1_en  = uses_rs1(in_class);
        in_dec.rs2_en  = uses_rs2(in_class);
        in_dec.illegal = (in_class == OcIllegal);
    end

    assign fire_in   = IF_VALID && if_ready_q;
    // Main can take new data if it is empty or its content leaves this cycle.
    assign main_free = !main_valid_q || ID_READY;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (main_free) begin
            if (skid_valid_q) begin
                // if_ready_q is low whenever skid is full, so no fetch beat here
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (fire_in) begin
                main_d       = in_dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (fire_in) begin
            skid_d       = in_dec;
            skid_valid_d = 1'b1;
        end
        if (FLUSH) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            if_ready_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            if_ready_q   <= !skid_valid_d;
        end
    end

    // Payload registers carry no reset; the valid flags qualify them.
    always_ff @(posedge CLK) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign IF_READY   = if_ready_q;
    assign ID_VALID   = main_valid_q;
    assign ID_PC      = main_q.pc;
    assign ID_INSTR   = main_q.instr;
    assign ID_OPCLASS = main_q.opclass;
    assign ID_RD      = main_q.rd;
    assign ID_RS1     = main_q.rs1;
    assign ID_RS2     = main_q.rs2;
    assign ID_FUNCT3  = main_q.funct3;
    assign ID_FUNCT7  = main_q.funct7;
    assign ID_IMM     = main_q.imm;
    assign ID_RD_WE   = main_q.rd_we;
    assign ID_RS1_EN  = main_q.rs1_en;
    assign ID_RS2_EN  = main_q.rs2_en;
    assign ID_ILLEGAL = main_q.illegal;

endmodule

// File: tb/tb_leve1_decode.sv
// Bench for leve1_decode: queue-based occupancy model plus a reference decoder,
// checked every cycle, with literal expectations at the directed scenarios.
module tb_leve1_decode;
    import leve1_pkg::*;

    typedef logic [192:0] rec_t;

    logic        CLK;
    logic        RST;
    logic        FLUSH;
    logic        IF_VALID;
    logic [63:0] IF_PC;
    logic [31:0] IF_INSTR;
    logic        IF_READY;
    logic        ID_VALID;
    logic        ID_READY;
    logic [63:0] ID_PC;
    logic [31:0] ID_INSTR;
    opclass_t    ID_OPCLASS;
    logic [4:0]  ID_RD;
    logic [4:0]  ID_RS1;
    logic [4:0]  ID_RS2;
    logic [2:0]  ID_FUNCT3;
    logic [6:0]  ID_FUNCT7;
    logic [63:0] ID_IMM;
    logic        ID_RD_WE;
    logic        ID_RS1_EN;
    logic        ID_RS2_EN;
    logic        ID_ILLEGAL;

    leve1_decode dut (
        .CLK        (CLK),
        .RST        (RST),
        .FLUSH      (FLUSH),
        .IF_VALID   (IF_VALID),
        .IF_PC      (IF_PC),
        .IF_INSTR   (IF_INSTR),
        .IF_READY   (IF_READY),
        .ID_VALID   (ID_VALID),
        .ID_READY   (ID_READY),
        .ID_PC      (ID_PC),
        .ID_INSTR   (ID_INSTR),
        .ID_OPCLASS (ID_OPCLASS),
        .ID_RD      (ID_RD),
        .ID_RS1     (ID_RS1),
        .ID_RS2     (ID_RS2),
        .ID_FUNCT3  (ID_FUNCT3),
        .ID_FUNCT7  (ID_FUNCT7),
        .ID_IMM     (ID_IMM),
        .ID_RD_WE   (ID_RD_WE),
        .ID_RS1_EN  (ID_RS1_EN),
        .ID_RS2_EN  (ID_RS2_EN),
        .ID_ILLEGAL (ID_ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decoder, written from the ISA rules.
    function automatic rec_t model_rec(input logic [63:0] pc, input logic [31:0] ins);
        logic [6:0]          op;
        logic [2:0]          f3;
        logic [6:0]          f7;
        logic [4:0]          rd;
        opclass_t            c;
        bit                  ok;
        logic signed [11:0]  i12;
        logic signed [11:0]  s12;
        logic signed [12:0]  b13;
        logic signed [31:0]  u32;
        logic signed [20:0]  j21;
        logic signed [63:0]  imm;
        logic                we;
        logic                r1;
        logic                r2;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        rd  = ins[11:7];
        ok  = 1'b1;
        c   = OcIllegal;
        case (op)
            7'h03: begin c = OcLoad;    ok = (f3 != 3'd7); end
            7'h23: begin c = OcStore;   ok = (f3 < 3'd4); end
            7'h63: begin c = OcBranch;  ok = !(f3 == 3'd2 || f3 == 3'd3); end
            7'h6F: c = OcJal;
            7'h67: begin c = OcJalr;    ok = (f3 == 3'd0); end
            7'h37: c = OcLui;
            7'h17: c = OcAuipc;
            7'h13: begin
                c = OcOpImm;
                if (f3 == 3'd1 || f3 == 3'd5)
                    ok = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h10);
            end
            7'h33, 7'h3B: begin
                c  = (op == 7'h33) ? OcOp : OcOp32;
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'h1B: begin
                c  = OcOpImm32;
                ok = (f3 == 3'd0) || ((f3 == 3'd1 || f3 == 3'd5) && (f7 == 7'h00 || f7 == 7'h20));
            end
            7'h0F: c = OcMiscMem;
            7'h73: c = OcSystem;
            default: ok = 1'b0;
        endcase
        if (ins[1:0] != 2'b11) ok = 1'b0;
        if (!ok) c = OcIllegal;
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        u32 = {ins[31:12], 12'h000};
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm = 64'sd0;
        if (c inside {OcLoad, OcJalr, OcOpImm, OcOpImm32, OcMiscMem, OcSystem}) imm = i12;
        else if (c == OcStore)                  imm = s12;
        else if (c == OcBranch)                 imm = b13;
        else if (c inside {OcLui, OcAuipc})     imm = u32;
        else if (c == OcJal)                    imm = j21;
        we = (c inside {OcLoad, OcJal, OcJalr, OcLui, OcAuipc, OcOpImm, OcOp, OcOpImm32, OcOp32})
             && (rd != 5'd0);
        r1 = c inside {OcLoad, OcStore, OcBranch, OcJalr, OcOpImm, OcOp, OcOpImm32, OcOp32};
        r2 = c inside {OcStore, OcBranch, OcOp, OcOp32};
        return {pc, ins, c, rd, ins[19:15], ins[24:20], f3, f7, imm, we, r1, r2, !ok};
    endfunction

    // Occupancy model: queue of beats held by decode, oldest first.
    rec_t q[$];
    bit   exp_ready = 1'b0;
    bit   live = 1'b0;

    always @(posedge CLK) begin
        bit in_fire;
        bit out_fire;
        if (RST) begin
            q.delete();
            exp_ready = 1'b0;
            live      = 1'b1;
        end else if (live) begin
            in_fire  = IF_VALID && exp_ready;
            out_fire = (q.size() > 0) && ID_READY;
            if (FLUSH) begin
                q.delete();
            end else begin
                if (out_fire) void'(q.pop_front());
                if (in_fire) q.push_back(model_rec(IF_PC, IF_INSTR));
            end
            exp_ready = (q.size() < 2);
        end
    end

    always @(negedge CLK) begin
        rec_t act;
        if (live) begin
            chk("if_ready", 64'(IF_READY), 64'(exp_ready));
            chk("id_valid", 64'(ID_VALID), 64'(q.size() > 0));
            if (q.size() > 0 && ID_VALID === 1'b1) begin
                act = {ID_PC, ID_INSTR, ID_OPCLASS, ID_RD, ID_RS1, ID_RS2, ID_FUNCT3,
                       ID_FUNCT7, ID_IMM, ID_RD_WE, ID_RS1_EN, ID_RS2_EN, ID_ILLEGAL};
                n_cmp++;
                if (act !== q[0]) begin
                    n_bad++;
                    $display("FAIL payload: got %0h expected %0h (t=%0t)", act, q[0], $time);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl, input logic rs);
        IF_VALID = v;
        IF_PC    = pc;
        IF_INSTR = ins;
        ID_READY = rdy;
        FLUSH    = fl;
        RST      = rs;
        @(negedge CLK);
    endtask

    localparam logic [31:0] IAddi = 32'h0050_0093;
    localparam logic [31:0] IBeq  = 32'hFE00_0EE3;
    localparam logic [31:0] ISw   = 32'h0020_A423;

    logic [31:0] tbl [16];

    initial begin
        tbl = '{32'h0050_0093, 32'hFE00_0EE3, 32'h0020_A423, 32'h0000_0000,
                32'h1234_5037, 32'h0080_00EF, 32'h4020_80B3, 32'h4020_9033,
                32'h0000_201B, 32'h0400_9093, 32'h0000_90E7, 32'h0000_7083,
                32'h0000_0073, 32'h0000_100F, 32'h4020_D09B, 32'h0001_3083};
        IF_VALID = 1'b0; IF_PC = '0; IF_INSTR = '0; ID_READY = 1'b0;
        FLUSH = 1'b0; RST = 1'b1;

        // Reset
        cyc(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 64'h0, IAddi, 1'b1, 1'b0, 1'b1);
        chk("rst_if_ready", 64'(IF_READY), 64'd0);
        chk("rst_id_valid", 64'(ID_VALID), 64'd0);
        cyc(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_if_ready", 64'(IF_READY), 64'd1);

        // Single-instruction decodes
        cyc(1'b1, 64'h8000_0000, IAddi, 1'b1, 1'b0, 1'b0);
        chk("addi_valid", 64'(ID_VALID), 64'd1);
        chk("addi_pc", ID_PC, 64'h8000_0000);
        chk("addi_class", 64'(ID_OPCLASS), 64'(OcOpImm));
        chk("addi_rd", 64'(ID_RD), 64'd1);
        chk("addi_rs1", 64'(ID_RS1), 64'd0);
        chk("addi_imm", ID_IMM, 64'd5);
        chk("addi_rd_we", 64'(ID_RD_WE), 64'd1);
        chk("addi_rs2_en", 64'(ID_RS2_EN), 64'd0);
        cyc(1'b1, 64'h8000_0004, IBeq, 1'b1, 1'b0, 1'b0);
        chk("beq_class", 64'(ID_OPCLASS), 64'(OcBranch));
        chk("beq_imm", ID_IMM, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_rd_we", 64'(ID_RD_WE), 64'd0);
        chk("beq_rs_en", {62'd0, ID_RS1_EN, ID_RS2_EN}, 64'd3);
        cyc(1'b1, 64'h8000_0008, ISw, 1'b1, 1'b0, 1'b0);
        chk("sw_class", 64'(ID_OPCLASS), 64'(OcStore));
        chk("sw_rs1", 64'(ID_RS1), 64'd1);
        chk("sw_rs2", 64'(ID_RS2), 64'd2);
        chk("sw_imm", ID_IMM, 64'd8);
        cyc(1'b1, 64'h8000_000C, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("zero_class", 64'(ID_OPCLASS), 64'(OcIllegal));
        chk("zero_illegal", 64'(ID_ILLEGAL), 64'd1);
        chk("zero_enables", {61'd0, ID_RD_WE, ID_RS1_EN, ID_RS2_EN}, 64'd0);
        cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_valid", 64'(ID_VALID), 64'd0);

        // Back-to-back beats into a stalled consumer
        cyc(1'b1, 64'h100, IAddi, 1'b0, 1'b0, 1'b0);
        chk("bb_a_pc", ID_PC, 64'h100);
        chk("bb_a_ready", 64'(IF_READY), 64'd1);
        cyc(1'b1, 64'h104, IBeq, 1'b0, 1'b0, 1'b0);
        chk("bb_hold_pc", ID_PC, 64'h100);
        chk("bb_skid_ready", 64'(IF_READY), 64'd0);
        cyc(1'b1, 64'h108, ISw, 1'b1, 1'b0, 1'b0);
        chk("bb_b_pc", ID_PC, 64'h104);
        chk("bb_b_ready", 64'(IF_READY), 64'd1);
        cyc(1'b1, 64'h108, ISw, 1'b1, 1'b0, 1'b0);
        chk("bb_c_pc", ID_PC, 64'h108);
        cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("bb_empty", 64'(ID_VALID), 64'd0);

        // Flush with main and skid full plus an incoming beat
        cyc(1'b1, 64'h200, IAddi, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h204, IBeq, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h208, ISw, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", 64'(ID_VALID), 64'd0);
        chk("flush_ready", 64'(IF_READY), 64'd1);
        cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_stale", 64'(ID_VALID), 64'd0);

        // Reset with both registers full
        cyc(1'b1, 64'h300, IAddi, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h304, IBeq, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h308, ISw, 1'b0, 1'b0, 1'b1);
        chk("midrst_valid", 64'(ID_VALID), 64'd0);
        chk("midrst_ready", 64'(IF_READY), 64'd0);
        cyc(1'b1, 64'h308, ISw, 1'b1, 1'b0, 1'b0);
        chk("midrst_after_ready", 64'(IF_READY), 64'd1);
        chk("midrst_after_valid", 64'(ID_VALID), 64'd0);
        cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Table sweep under a patterned stall profile
        for (int k = 0; k < 64; k++) begin
            cyc((k % 5) != 4, 64'h1000 + 64'(k * 4), tbl[k % 16], (k % 3) != 1, k == 41, 1'b0);
        end
        for (int k = 0; k < 4; k++) cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("end_empty", 64'(ID_VALID), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
